// File: rtl/shift_ctrl_pkg.sv
// Shared constants, request payload type and shift-amount saturation helper
// for the shared barrel shifter and its arbiter.
package shift_ctrl_pkg;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned SHAMT_W    = 6;
   localparam int unsigned SHAMT_SAT  = 32;

   localparam logic [1:0] SHIFTLEFT   = 2'b00;
   localparam logic [1:0] SHIFTRIGHT  = 2'b10;
   localparam logic [1:0] SHIFTRIGHTA = 2'b11;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] b;
      logic [1:0]            op;
   } shift_req_t;

   // Any amount of 32 or more collapses to exactly 32 so the shifter only sees 0..32.
   function automatic logic [SHAMT_W-1:0] sat_shamt(input logic [DATA_WIDTH-1:0] b);
      if (|b[DATA_WIDTH-1:5]) return SHAMT_W'(SHAMT_SAT);
      return SHAMT_W'(b[4:0]);
   endfunction

endpackage

// File: rtl/shift_req_arbiter_if.sv
// Request/response bundle between NUM_REQ shift requesters, the result
// consumer (master side) and shift_req_arbiter (slave side).
interface shift_req_arbiter_if #(
   parameter int unsigned NUM_REQ = 2
);
   import shift_ctrl_pkg::*;

   localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
   logic [NUM_REQ*2-1:0]          req_op;
   logic                          rsp_valid;
   logic                          rsp_ready;
   logic [ID_W-1:0]               rsp_id;
   logic [DATA_WIDTH-1:0]         rsp_result;

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result
   );

endinterface

// File: rtl/barrel_shifter.sv
// Combinational 32-bit barrel shifter; amount is pre-saturated to 0..32,
// reserved opcode yields zero.
module barrel_shifter
   import shift_ctrl_pkg::*;
(
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [SHAMT_W-1:0]    shamt,
   input  logic [1:0]            op,
   output logic [DATA_WIDTH-1:0] result_c
);

   always_comb begin
      result_c = '0;
      case (op)
         SHIFTLEFT:   result_c = shamt[SHAMT_W-1] ? '0 : (a << shamt[4:0]);
         SHIFTRIGHT:  result_c = shamt[SHAMT_W-1] ? '0 : (a >> shamt[4:0]);
         SHIFTRIGHTA: result_c = shamt[SHAMT_W-1] ? {DATA_WIDTH{a[DATA_WIDTH-1]}}
                                                  : DATA_WIDTH'($signed(a) >>> shamt[4:0]);
         default:     result_c = '0;
      endcase
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr wins,
// reported as one-hot grant plus encoded index.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ID_W    = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt_c,
   output logic [ID_W-1:0]    gnt_idx_c,
   output logic               gnt_any_c
);

   always_comb begin
      logic [ID_W-1:0] idx;
      gnt_c     = '0;
      gnt_idx_c = '0;
      gnt_any_c = 1'b0;
      idx       = '0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         idx = ID_W'((32'(ptr) + off) % NUM_REQ);
         if (!gnt_any_c && req[idx]) begin
            gnt_any_c  = 1'b1;
            gnt_c[idx] = 1'b1;
            gnt_idx_c  = idx;
         end
      end
   end

endmodule

// File: rtl/shift_req_arbiter.sv
// Shares one barrel shifter among NUM_REQ requesters, round-robin, with a
// single registered result slot. Define SHIFT_PERF_CNT_EN for per-requester grant counters.
module shift_req_arbiter
   import shift_ctrl_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   shift_req_arbiter_if.slave            bus,
   output logic [NUM_REQ*DATA_WIDTH-1:0] perf_grant
);

   localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0]            state, state_nxt;
   logic [ID_W-1:0]       ptr;
   logic [NUM_REQ-1:0]    gnt_c;
   logic [ID_W-1:0]       gnt_idx_c;
   logic                  gnt_any_c;
   logic                  can_accept_c;
   logic                  handshake_c;
   shift_req_t            sel_c;
   logic [SHAMT_W-1:0]    shamt_c;
   logic [DATA_WIDTH-1:0] shift_res_c;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr_arbiter (
      .req       (bus.req_valid),
      .ptr       (ptr),
      .gnt_c     (gnt_c),
      .gnt_idx_c (gnt_idx_c),
      .gnt_any_c (gnt_any_c)
   );

   // Operand mux for the granted requester
   always_comb begin
      sel_c.a  = bus.req_a[int'(gnt_idx_c)*DATA_WIDTH +: DATA_WIDTH];
      sel_c.b  = bus.req_b[int'(gnt_idx_c)*DATA_WIDTH +: DATA_WIDTH];
      sel_c.op = bus.req_op[int'(gnt_idx_c)*2 +: 2];
      shamt_c  = sat_shamt(sel_c.b);
   end

   barrel_shifter u_barrel_shifter (
      .a        (sel_c.a),
      .shamt    (shamt_c),
      .op       (sel_c.op),
      .result_c (shift_res_c)
   );

   assign can_accept_c  = (state == EMPTY) || bus.rsp_ready;
   assign handshake_c   = can_accept_c && gnt_any_c;
   assign bus.req_ready = can_accept_c ? gnt_c : '0;
   assign bus.rsp_valid = (state == FULL);

   always_ff @(posedge clk) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (handshake_c) state_nxt = FULL;
         FULL:    if (handshake_c)        state_nxt = FULL;
                  else if (bus.rsp_ready) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   // Result slot and RR pointer only move on a handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr            <= '0;
         bus.rsp_id     <= '0;
         bus.rsp_result <= '0;
      end else if (handshake_c) begin
         ptr            <= (gnt_idx_c == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_c + ID_W'(1);
         bus.rsp_id     <= gnt_idx_c;
         bus.rsp_result <= shift_res_c;
      end
   end

`ifdef SHIFT_PERF_CNT_EN
   logic [DATA_WIDTH-1:0] perf_cnt [NUM_REQ];

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (rst)                          perf_cnt[i] <= '0;
         else if (handshake_c && gnt_c[i]) perf_cnt[i] <= perf_cnt[i] + DATA_WIDTH'(1);
      end
   end

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
      assign perf_grant[gi*DATA_WIDTH +: DATA_WIDTH] = perf_cnt[gi];
   end
`else
   assign perf_grant = '0;
`endif

endmodule
